// File: rtl/bus_cycle_ctrl_8088.sv
// 8088 bus-cycle sequencer: turns EU transfers and code prefetches into T1-T4 bus
// cycles with READY wait states, HOLD/HLDA arbitration and prefetch-queue bookkeeping.
module bus_cycle_ctrl_8088 #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [15:0] RESET_IP    = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [2:0]  REQ_TYPE,
    input  logic [1:0]  REQ_SEG,
    input  logic [15:0] REQ_OFS,
    input  logic [7:0]  REQ_WDATA,
    output logic        ACK,
    output logic [7:0]  RDATA,
    input  logic [7:0]  AD_IN,
    output logic [7:0]  AD_OUT,
    output logic        AD_OE,
    output logic        IOM,
    output logic        DTR,
    output logic        DEN,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        INTA_N,
    input  logic        READY,
    input  logic        HOLD,
    output logic        HLDA,
    output logic [1:0]  SEG_SEL,
    output logic [15:0] ADDR_OFS,
    output logic        QUEUE_ENA,
    output logic [7:0]  QUEUE_IN,
    input  logic        QUEUE_POP,
    input  logic        QUEUE_FLUSH,
    input  logic [15:0] NEW_IP,
    output logic [2:0]  QUEUE_CNT
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_HOLD} state_t;
    typedef enum logic [2:0] {K_FETCH, K_MRD, K_MWR, K_IORD, K_IOWR, K_INTA} kind_t;

    localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);
    localparam logic [1:0] SEG_CS = 2'b01;

    state_t      r_state;
    kind_t       r_kind;
    logic        r_flushed;
    logic [7:0]  r_wdata;
    logic [15:0] r_ip;

    kind_t       w_req_kind;
    logic        w_req_io;
    logic        w_req_wr;
    logic        w_is_wr;
    logic        w_is_inta;
    logic        w_is_fetch;
    logic        w_pop;
    logic [2:0]  w_cnt_next;
    logic        w_fetch_ok;
    logic        w_ready_exit;
    logic        w_fetch_done;
    logic [15:0] w_ip_next;

    always_comb begin
        case (REQ_TYPE)
            3'b001:  w_req_kind = K_MWR;
            3'b010:  w_req_kind = K_IORD;
            3'b011:  w_req_kind = K_IOWR;
            3'b100:  w_req_kind = K_INTA;
            default: w_req_kind = K_MRD;
        endcase
    end

    always_comb begin
        w_req_io     = (w_req_kind == K_IORD) || (w_req_kind == K_IOWR);
        w_req_wr     = (w_req_kind == K_MWR)  || (w_req_kind == K_IOWR);
        w_is_wr      = (r_kind == K_MWR) || (r_kind == K_IOWR);
        w_is_inta    = (r_kind == K_INTA);
        w_is_fetch   = (r_kind == K_FETCH);
        w_pop        = QUEUE_POP && (QUEUE_CNT != '0);
        // Occupancy after this edge; arbitration uses it so a fetch completing in T4 counts.
        w_cnt_next   = QUEUE_FLUSH ? '0 : QUEUE_CNT + {2'b00, QUEUE_ENA} - {2'b00, w_pop};
        w_fetch_ok   = !QUEUE_FLUSH && (w_cnt_next < DEPTH);
        w_ready_exit = ((r_state == S_T3) || (r_state == S_TW)) && READY;
        w_fetch_done = w_ready_exit && w_is_fetch && !r_flushed && !QUEUE_FLUSH;
        w_ip_next    = QUEUE_FLUSH ? NEW_IP : (w_fetch_done ? r_ip + 16'd1 : r_ip);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_kind    <= K_FETCH;
            r_flushed <= 1'b0;
            r_wdata   <= '0;
            r_ip      <= RESET_IP;
            ALE       <= 1'b0;
            RD        <= 1'b1;
            WR        <= 1'b1;
            DEN       <= 1'b1;
            INTA_N    <= 1'b1;
            DTR       <= 1'b0;
            IOM       <= 1'b0;
            AD_OE     <= 1'b0;
            AD_OUT    <= '0;
            ACK       <= 1'b0;
            RDATA     <= '0;
            HLDA      <= 1'b0;
            QUEUE_ENA <= 1'b0;
            QUEUE_IN  <= '0;
            QUEUE_CNT <= '0;
            SEG_SEL   <= SEG_CS;
            ADDR_OFS  <= RESET_IP;
        end else begin
            QUEUE_CNT <= w_cnt_next;
            r_ip      <= w_ip_next;
            ACK       <= 1'b0;
            QUEUE_ENA <= 1'b0;

            case (r_state)
                S_IDLE, S_T4: begin
                    AD_OE <= 1'b0;
                    if (HOLD) begin
                        r_state <= S_HOLD;
                        HLDA    <= 1'b1;
                    end else if (REQ) begin
                        r_state   <= S_T1;
                        r_kind    <= w_req_kind;
                        r_flushed <= 1'b0;
                        r_wdata   <= REQ_WDATA;
                        ALE       <= 1'b1;
                        IOM       <= w_req_io;
                        DTR       <= w_req_wr;
                        SEG_SEL   <= REQ_SEG;
                        ADDR_OFS  <= REQ_OFS;
                    end else if (w_fetch_ok) begin
                        r_state   <= S_T1;
                        r_kind    <= K_FETCH;
                        r_flushed <= 1'b0;
                        ALE       <= 1'b1;
                        IOM       <= 1'b0;
                        DTR       <= 1'b0;
                        SEG_SEL   <= SEG_CS;
                        ADDR_OFS  <= r_ip;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_T1: begin
                    r_state <= S_T2;
                    ALE     <= 1'b0;
                    DEN     <= 1'b0;
                    RD      <= w_is_wr || w_is_inta;
                    WR      <= !w_is_wr;
                    INTA_N  <= !w_is_inta;
                    if (w_is_wr) begin
                        AD_OE  <= 1'b1;
                        AD_OUT <= r_wdata;
                    end
                    if (QUEUE_FLUSH && w_is_fetch) r_flushed <= 1'b1;
                end
                S_T2: begin
                    r_state <= S_T3;
                    if (QUEUE_FLUSH && w_is_fetch) r_flushed <= 1'b1;
                end
                S_T3, S_TW: begin
                    if (QUEUE_FLUSH && w_is_fetch) r_flushed <= 1'b1;
                    if (READY) begin
                        r_state <= S_T4;
                        RD      <= 1'b1;
                        WR      <= 1'b1;
                        INTA_N  <= 1'b1;
                        DEN     <= 1'b1;
                        if (w_is_fetch) begin
                            if (w_fetch_done) begin
                                QUEUE_ENA <= 1'b1;
                                QUEUE_IN  <= AD_IN;
                            end
                        end else begin
                            ACK <= 1'b1;
                            if (!w_is_wr) RDATA <= AD_IN;
                        end
                    end else begin
                        r_state <= S_TW;
                    end
                end
                S_HOLD: begin
                    if (!HOLD) begin
                        r_state <= S_IDLE;
                        HLDA    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl_8088.sv
// Randomized self-checking bench for bus_cycle_ctrl_8088 against a bus-cycle-level
// reference model that tracks the clock position within each transfer.
module tb_bus_cycle_ctrl_8088;

    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] RIP   = 16'h0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ = 1'b0;
    logic [2:0]  REQ_TYPE = '0;
    logic [1:0]  REQ_SEG = '0;
    logic [15:0] REQ_OFS = '0;
    logic [7:0]  REQ_WDATA = '0;
    logic [7:0]  AD_IN = '0;
    logic        READY = 1'b1;
    logic        HOLD = 1'b0;
    logic        QUEUE_POP = 1'b0;
    logic        QUEUE_FLUSH = 1'b0;
    logic [15:0] NEW_IP = '0;

    logic        ACK, AD_OE, IOM, DTR, DEN, ALE, RD, WR, INTA_N, HLDA, QUEUE_ENA;
    logic [7:0]  RDATA, AD_OUT, QUEUE_IN;
    logic [1:0]  SEG_SEL;
    logic [15:0] ADDR_OFS;
    logic [2:0]  QUEUE_CNT;

    bus_cycle_ctrl_8088 #(.QUEUE_DEPTH(DEPTH), .RESET_IP(RIP)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_TYPE(REQ_TYPE), .REQ_SEG(REQ_SEG),
        .REQ_OFS(REQ_OFS), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .RDATA(RDATA),
        .AD_IN(AD_IN), .AD_OUT(AD_OUT), .AD_OE(AD_OE), .IOM(IOM), .DTR(DTR),
        .DEN(DEN), .ALE(ALE), .RD(RD), .WR(WR), .INTA_N(INTA_N), .READY(READY),
        .HOLD(HOLD), .HLDA(HLDA), .SEG_SEL(SEG_SEL), .ADDR_OFS(ADDR_OFS),
        .QUEUE_ENA(QUEUE_ENA), .QUEUE_IN(QUEUE_IN), .QUEUE_POP(QUEUE_POP),
        .QUEUE_FLUSH(QUEUE_FLUSH), .NEW_IP(NEW_IP), .QUEUE_CNT(QUEUE_CNT)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a transfer is a sequence of clocks numbered 1 (address),
    // 2 (strobe), 3 (data, repeated while READY low) and 4 (completion).
    bit          m_busy, m_hold, m_fetch, m_dead, m_ack, m_qena, m_iom, m_dtr;
    int          m_pos, m_cnt;
    logic [2:0]  m_typ;
    logic [1:0]  m_seg;
    logic [15:0] m_ofs, m_ip;
    logic [7:0]  m_wd, m_adout, m_rdata, m_qin;

    function automatic bit is_wr(input logic [2:0] t);
        return (t == 3'd1) || (t == 3'd3);
    endfunction
    function automatic bit is_io(input logic [2:0] t);
        return (t == 3'd2) || (t == 3'd3);
    endfunction
    function automatic bit is_inta(input logic [2:0] t);
        return t == 3'd4;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_hold = 0; m_fetch = 0; m_dead = 0; m_ack = 0; m_qena = 0;
        m_iom = 0; m_dtr = 0; m_pos = 0; m_cnt = 0; m_typ = '0;
        m_seg = 2'b01; m_ofs = RIP; m_ip = RIP;
        m_wd = '0; m_adout = '0; m_rdata = '0; m_qin = '0;
    endtask

    task automatic model_step();
        bit pop;
        bit fl;
        int cnt_n;
        fl    = QUEUE_FLUSH;
        pop   = QUEUE_POP && (m_cnt > 0);
        cnt_n = fl ? 0 : m_cnt + int'(m_qena) - int'(pop);
        m_ack  = 0;
        m_qena = 0;
        if (m_hold) begin
            if (!HOLD) m_hold = 0;
        end else if (!m_busy || m_pos == 4) begin
            m_busy = 0;
            if (HOLD) begin
                m_hold = 1;
            end else if (REQ) begin
                m_busy = 1; m_pos = 1; m_fetch = 0; m_dead = 0;
                m_typ = (REQ_TYPE > 3'd4) ? 3'd0 : REQ_TYPE;
                m_seg = REQ_SEG; m_ofs = REQ_OFS; m_wd = REQ_WDATA;
                m_iom = is_io(m_typ); m_dtr = is_wr(m_typ);
            end else if (!fl && cnt_n < int'(DEPTH)) begin
                m_busy = 1; m_pos = 1; m_fetch = 1; m_dead = 0; m_typ = '0;
                m_seg = 2'b01; m_ofs = m_ip; m_iom = 0; m_dtr = 0;
            end
        end else begin
            if (fl && m_fetch) m_dead = 1;
            if (m_pos < 3) begin
                m_pos++;
                if (m_pos == 2 && is_wr(m_typ)) m_adout = m_wd;
            end else if (READY) begin
                m_pos = 4;
                if (m_fetch) begin
                    if (!m_dead) begin
                        m_qena = 1; m_qin = AD_IN; m_ip = m_ip + 16'd1;
                    end
                end else begin
                    m_ack = 1;
                    if (!is_wr(m_typ)) m_rdata = AD_IN;
                end
            end
        end
        if (fl) m_ip = NEW_IP;
        m_cnt = cnt_n;
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) model_reset();
        else model_step();
    end

    task automatic check_all();
        bit mid;
        bit rd_cyc;
        mid    = m_busy && (m_pos == 2 || m_pos == 3);
        rd_cyc = m_fetch || (!is_wr(m_typ) && !is_inta(m_typ));
        check_eq("ALE", ALE, m_busy && m_pos == 1);
        check_eq("RD", RD, !(mid && rd_cyc));
        check_eq("WR", WR, !(mid && !m_fetch && is_wr(m_typ)));
        check_eq("INTA_N", INTA_N, !(mid && !m_fetch && is_inta(m_typ)));
        check_eq("DEN", DEN, !mid);
        check_eq("AD_OE", AD_OE, m_busy && !m_fetch && is_wr(m_typ) && m_pos >= 2);
        check_eq("AD_OUT", AD_OUT, m_adout);
        check_eq("IOM", IOM, m_iom);
        check_eq("DTR", DTR, m_dtr);
        check_eq("HLDA", HLDA, m_hold);
        check_eq("ACK", ACK, m_ack);
        check_eq("RDATA", RDATA, m_rdata);
        check_eq("QUEUE_ENA", QUEUE_ENA, m_qena);
        check_eq("QUEUE_IN", QUEUE_IN, m_qin);
        check_eq("QUEUE_CNT", QUEUE_CNT, m_cnt);
        check_eq("SEG_SEL", SEG_SEL, m_seg);
        check_eq("ADDR_OFS", ADDR_OFS, m_ofs);
    endtask

    initial begin
        int ale_cnt;
        int tw_seen;
        bit found;

        // Reset, then free-running prefetch with an idle EU.
        repeat (2) @(negedge CLK);
        check_all();
        RST = 1'b0;
        ale_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check_all();
            if (ALE) begin
                check_eq("fill_addr", ADDR_OFS, 32'(ale_cnt));
                ale_cnt++;
            end
            AD_IN = 8'($urandom);
        end
        check_eq("fill_ale_pulses", 32'(ale_cnt), 32'd4);
        check_eq("fill_cnt", QUEUE_CNT, 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            check_all();
            if (m_ack) begin
                REQ = 1'b0;
            end else if (!REQ && $urandom_range(0, 5) == 0) begin
                REQ       = 1'b1;
                REQ_TYPE  = 3'($urandom);
                REQ_SEG   = 2'($urandom);
                REQ_OFS   = 16'($urandom);
                REQ_WDATA = 8'($urandom);
            end
            READY       = $urandom_range(0, 3) != 0;
            HOLD        = HOLD ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 30) == 0);
            QUEUE_POP   = $urandom_range(0, 2) == 0;
            QUEUE_FLUSH = $urandom_range(0, 25) == 0;
            NEW_IP      = 16'($urandom);
            AD_IN       = 8'($urandom);
        end

        // IO read stalled in a wait state, then asynchronous reset.
        @(negedge CLK);
        check_all();
        HOLD = 1'b0; QUEUE_FLUSH = 1'b0; QUEUE_POP = 1'b0; READY = 1'b1;
        if (m_ack) begin
            REQ = 1'b0;
            @(negedge CLK);
            check_all();
        end
        REQ = 1'b1; REQ_TYPE = 3'b010; REQ_SEG = 2'b00; REQ_OFS = 16'h0060;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge CLK);
            check_all();
            if (m_busy && !m_fetch && m_pos == 1) found = 1;
        end
        check_eq("io_rd_start_seen", 32'(found), 32'd1);
        READY = 1'b0;
        tw_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_all();
            if (m_pos == 3) tw_seen++;
        end
        check_eq("io_rd_tw_rd_low", RD, 32'd0);
        check_eq("io_rd_tw_iom", IOM, 32'd1);
        check_eq("io_rd_tw_pos", 32'(tw_seen), 32'd2);
        #2 RST = 1'b1;
        #1;
        check_eq("arst_RD", RD, 32'd1);
        check_eq("arst_DEN", DEN, 32'd1);
        check_eq("arst_IOM", IOM, 32'd0);
        check_eq("arst_SEG", SEG_SEL, 32'd1);
        check_eq("arst_OFS", ADDR_OFS, 32'(RIP));
        check_eq("arst_CNT", QUEUE_CNT, 32'd0);
        @(negedge CLK);
        check_all();
        RST = 1'b0; REQ = 1'b0; READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            check_all();
            AD_IN = 8'($urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
